// File: rtl/platform_ram_arb_pkg.sv
// Shared types and defaults for the two-master on-chip RAM arbiter.
package platform_ram_arb_pkg;

  typedef logic master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = DEF_DATA_W / 8;

  // Width of the watchdog counter, which must be able to hold LOCK_MAX.
  function automatic int lock_cnt_w(input int lock_max);
    return $clog2(lock_max + 1);
  endfunction

endpackage

// File: rtl/platform_ram_rr_pick.sv
// Combinational 2-way round-robin pick, restricted to the lock owner while a
// lock is held.
module platform_ram_rr_pick
  import platform_ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t last_grant,
  input  logic       lock_valid,
  input  master_id_t lock_owner,
  output logic       gnt_valid,
  output master_id_t gnt_id
);

  // Pick the next master: owner only under lock, otherwise alternate on ties.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = M0;
    if (lock_valid) begin
      gnt_valid = req[lock_owner];
      gnt_id    = lock_owner;
    end else if (req[0] && req[1]) begin
      gnt_valid = 1'b1;
      gnt_id    = ~last_grant;
    end else if (req[0]) begin
      gnt_valid = 1'b1;
      gnt_id    = M0;
    end else if (req[1]) begin
      gnt_valid = 1'b1;
      gnt_id    = M1;
    end
  end

endmodule

// File: rtl/platform_ram_arbiter.sv
// Time-multiplexes one single-port RAM between two Avalon-MM slave ports with
// round-robin grant, an owner lock for atomic read-modify-write, and a
// watchdog that force-releases a lock whose owner stops requesting.
module platform_ram_arbiter
  import platform_ram_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BE_W     = DEF_BE_W,
  parameter int LOCK_MAX = 64
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic              m0_lock,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic              m1_lock,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  localparam int CNT_W = lock_cnt_w(LOCK_MAX);
  // Last idle count before release; the release lands on the LOCK_MAX-th idle edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  logic [1:0]       req;
  master_id_t       last_grant;
  logic             lock_valid;
  master_id_t       lock_owner;
  logic [CNT_W-1:0] lock_cnt;
  logic             rd_vld;
  master_id_t       rd_own;

  logic             pick_valid;
  master_id_t       pick_id;
  logic             gnt_valid;
  logic             gnt_write;
  logic             gnt_lock;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  platform_ram_rr_pick u_pick (
    .req        (req),
    .last_grant (last_grant),
    .lock_valid (lock_valid),
    .lock_owner (lock_owner),
    .gnt_valid  (pick_valid),
    .gnt_id     (pick_id)
  );

  // Nothing is granted while reset is held, whatever the masters request.
  assign gnt_valid = pick_valid & ~reset;
  assign gnt_write = (pick_id == M1) ? m1_write : m0_write;
  assign gnt_lock  = (pick_id == M1) ? m1_lock  : m0_lock;

  assign m0_waitrequest = ~(gnt_valid && pick_id == M0);
  assign m1_waitrequest = ~(gnt_valid && pick_id == M1);

  assign ram_address    = (pick_id == M1) ? m1_address    : m0_address;
  assign ram_byteenable = (pick_id == M1) ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = (pick_id == M1) ? m1_writedata  : m0_writedata;
  assign ram_chipselect = gnt_valid;
  assign ram_write      = gnt_valid & gnt_write;
  assign ram_clken      = 1'b1;

  // RAM read data is shared; only the owner's valid strobe qualifies it.
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rd_vld && rd_own == M0;
  assign m1_readdatavalid = rd_vld && rd_own == M1;

  // Round-robin history and the one-deep read return pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= M1;
      rd_vld     <= 1'b0;
      rd_own     <= M0;
    end else begin
      if (gnt_valid) last_grant <= pick_id;
      rd_vld <= gnt_valid & ~gnt_write;
      rd_own <= pick_id;
    end
  end

  // Lock ownership and abandoned-lock watchdog; an owner request in the
  // release cycle takes precedence over the force-release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_owner <= M0;
      lock_cnt   <= '0;
    end else if (lock_valid) begin
      if (req[lock_owner]) begin
        lock_cnt <= '0;
        if (gnt_valid && !gnt_lock) lock_valid <= 1'b0;
      end else if (lock_cnt == CNT_LAST) begin
        lock_valid <= 1'b0;
        lock_cnt   <= '0;
      end else begin
        lock_cnt <= lock_cnt + 1'b1;
      end
    end else begin
      lock_cnt <= '0;
      if (gnt_valid && gnt_lock) begin
        lock_valid <= 1'b1;
        lock_owner <= pick_id;
      end
    end
  end

endmodule

// File: tb/tb_platform_ram_arbiter.sv
// Directed bench for platform_ram_arbiter with a behavioural RAM and a
// read-return scoreboard.
module tb_platform_ram_arbiter;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          cyc;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [11:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          sb_push = 1'b1;
  rd_exp_t     sb[$];
  logic [31:0] shadow [0:4095];
  logic [31:0] mem [0:4095];
  bit          mem_init = 1'b0;

  platform_ram_arbiter #(.ADDR_W(12), .DATA_W(32), .BE_W(4), .LOCK_MAX(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_lock          (m0_lock),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_lock          (m1_lock),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pattern(input int i);
    return 32'hC0DE0000 | (i & 32'h0000FFFF);
  endfunction

  // Single-port RAM: byte-lane writes, registered read data one cycle later.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pattern(i);
      mem_init <= 1'b1;
    end else if (ram_chipselect && ram_clken) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ret(input logic id, input logic [31:0] data);
    rd_exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL rd_unexpected observed=valid_on_m%0d expected=no_valid", id);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rd_owner", {31'b0, id}, {31'b0, e.id});
      chk("rd_data", data, e.data);
      chk("rd_latency", cyc, e.cyc + 1);
    end
  endtask

  // Returned reads are matched against the scoreboard mid-cycle.
  always @(negedge clk) begin
    if (m0_readdatavalid) check_ret(1'b0, m0_readdata);
    if (m1_readdatavalid) check_ret(1'b1, m1_readdata);
  end

  task automatic model_access(input logic id, input logic r, input logic w,
                              input logic [11:0] a, input logic [3:0] be,
                              input logic [31:0] d);
    rd_exp_t e;
    chk("ram_address", {20'b0, ram_address}, {20'b0, a});
    chk("ram_write", {31'b0, ram_write}, {31'b0, w});
    if (w) begin
      chk("ram_byteenable", {28'b0, ram_byteenable}, {28'b0, be});
      chk("ram_writedata", ram_writedata, d);
      for (int b = 0; b < 4; b++)
        if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
    end else if (r && sb_push) begin
      e.id   = id;
      e.data = shadow[a];
      e.cyc  = cyc;
      sb.push_back(e);
    end
  endtask

  // One bus cycle: exp_g is the expected grant (0 = m0, 1 = m1, 2 = none).
  task automatic tick(input int exp_g, input string tag);
    @(negedge clk);
    chk({tag, "_wait0"}, {31'b0, m0_waitrequest}, {31'b0, exp_g != 0});
    chk({tag, "_wait1"}, {31'b0, m1_waitrequest}, {31'b0, exp_g != 1});
    chk({tag, "_cs"}, {31'b0, ram_chipselect}, {31'b0, exp_g != 2});
    if (exp_g == 0)
      model_access(1'b0, m0_read, m0_write, m0_address, m0_byteenable, m0_writedata);
    else if (exp_g == 1)
      model_access(1'b1, m1_read, m1_write, m1_address, m1_byteenable, m1_writedata);
    @(posedge clk);
    #1;
  endtask

  task automatic check_in_reset(input string tag);
    @(negedge clk);
    chk({tag, "_wait0"}, {31'b0, m0_waitrequest}, 32'd1);
    chk({tag, "_wait1"}, {31'b0, m1_waitrequest}, 32'd1);
    chk({tag, "_cs"}, {31'b0, ram_chipselect}, 32'd0);
    chk({tag, "_wr"}, {31'b0, ram_write}, 32'd0);
    chk({tag, "_rdv0"}, {31'b0, m0_readdatavalid}, 32'd0);
    chk({tag, "_rdv1"}, {31'b0, m1_readdatavalid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) shadow[i] = pattern(i);
    reset = 1'b1;
    m0_address = 12'h010; m0_byteenable = 4'hF; m0_read = 1'b1; m0_write = 1'b0;
    m0_lock = 1'b0; m0_writedata = '0;
    m1_address = 12'h020; m1_byteenable = 4'hF; m1_read = 1'b1; m1_write = 1'b0;
    m1_lock = 1'b0; m1_writedata = '0;

    // Reset state with both masters requesting.
    repeat (2) @(posedge clk);
    check_in_reset("reset");
    chk("clken", {31'b0, ram_clken}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Dual reads alternate starting with m0.
    tick(0, "rr0");
    tick(1, "rr1");
    tick(0, "rr2");
    tick(1, "rr3");

    // Partial write then read back.
    m1_read = 1'b0;
    m0_read = 1'b0; m0_write = 1'b1; m0_address = 12'h100;
    m0_byteenable = 4'b0011; m0_writedata = 32'hDEADBEEF;
    tick(0, "wr_be");
    m0_write = 1'b0; m0_read = 1'b1; m0_byteenable = 4'hF;
    tick(0, "rd_be");

    // m1 locks for read-modify-write while m0 keeps requesting.
    m0_address = 12'h005;
    m1_read = 1'b1; m1_lock = 1'b1; m1_address = 12'h005;
    tick(1, "lk_set");
    m1_read = 1'b0; m1_lock = 1'b0;
    tick(2, "lk_hold");
    tick(2, "lk_hold");
    m1_write = 1'b1; m1_writedata = 32'h12345678;
    tick(1, "lk_unlock");
    m1_write = 1'b0;
    tick(0, "lk_after");
    m0_read = 1'b0;

    // m0 abandons a lock; m1 is admitted after the watchdog expires.
    m0_read = 1'b1; m0_lock = 1'b1; m0_address = 12'h030;
    tick(0, "wd_lock");
    m0_read = 1'b0; m0_lock = 1'b0;
    m1_read = 1'b1; m1_address = 12'h040;
    for (int i = 0; i < 64; i++) tick(2, "wd_hold");
    tick(1, "wd_release");

    // Owner request in the would-be release cycle keeps the lock and restarts the count.
    m1_lock = 1'b1; m1_address = 12'h050;
    tick(1, "sim_lock");
    m1_read = 1'b0; m1_lock = 1'b0;
    m0_read = 1'b1; m0_address = 12'h060;
    for (int i = 0; i < 63; i++) tick(2, "sim_idle");
    m1_read = 1'b1; m1_lock = 1'b1;
    tick(1, "sim_owner_req");
    m1_read = 1'b0; m1_lock = 1'b0;
    for (int i = 0; i < 64; i++) tick(2, "sim_hold");
    tick(0, "sim_release");

    // Reset lands the cycle after a granted read; the read must be dropped.
    m0_address = 12'h070;
    sb_push = 1'b0;
    tick(0, "abort_rd");
    reset = 1'b1;
    m1_read = 1'b1; m1_address = 12'h020;
    check_in_reset("abort_rst");
    @(posedge clk);
    check_in_reset("abort_rst2");
    @(posedge clk);
    #1 reset = 1'b0;
    sb_push = 1'b1;
    m0_address = 12'h010;
    tick(0, "post_rst_tie");
    tick(1, "post_rst_alt");

    // m0 alone streams ten back-to-back reads.
    m1_read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      m0_address = 12'h200 + 12'(i);
      tick(0, "solo");
    end
    m0_read = 1'b0;
    tick(2, "drain");
    tick(2, "drain");

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/platform_ram_arbiter.md
# platform_ram_arbiter

Two-master arbiter for the platform's 4096×32 single-port on-chip RAM.
- Two processes/CPUs share the RAM for synchronized message passing; the RAM's one port is time-multiplexed between two Avalon-MM slave ports (m0, m1).
- Round-robin grant, one RAM access per cycle.
- Lock mechanism gives a master uninterrupted access for atomic read-modify-write (mailbox/semaphore updates).
- Watchdog force-releases a lock that is abandoned.

## Interface
Parameters:
- ADDR_W, 12, RAM word-address width
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- LOCK_MAX, 64, idle cycles after which an abandoned lock is force-released (≥2)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- mN_address  in  ADDR_W  master N word address (N = 0, 1; same set for each)
- mN_byteenable  in  BE_W  byte lanes for writes
- mN_read / mN_write  in  1  request strobes; never both high
- mN_lock  in  1  hold grant after this transfer
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  high = transfer not accepted this cycle
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  one-cycle strobe qualifying mN_readdata
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  BE_W  to RAM
- ram_chipselect  out  1  to RAM
- ram_write  out  1  to RAM
- ram_writedata  out  DATA_W  to RAM
- ram_clken  out  1  tied 1
- ram_readdata  in  DATA_W  from RAM, valid the cycle after the address

## Operation
- Request: reqN = mN_read | mN_write.
- Grant is combinational each cycle:
  - Lock held: only the lock owner may be granted.
  - No lock, both requesting: grant goes to the master not in last_grant.
  - No lock, one requesting: that master is granted.
- Granted master: waitrequest=0, and its address/byteenable/writedata are driven onto the ram_* outputs.
  - ram_chipselect=1.
  - ram_write=mN_write.
- Other master: waitrequest=1 whenever it requests.
- Idle master: waitrequest=1.
- Nothing granted: ram_chipselect=0 and ram_write=0.
- last_grant updates to N on every granted transfer.
- Read return pipeline:
  - rd_vld/rd_own registers capture (granted read, owner) at each edge.
  - Next cycle, mOwner_readdatavalid = rd_vld and both mN_readdata = ram_readdata.
- Lock:
  - A granted transfer with mN_lock=1 sets lock_valid=1, lock_owner=N.
  - A granted transfer by the owner with lock=0 clears lock_valid.
  - Non-owner lock is ignored while a lock is held.
- Watchdog:
  - Counter increments each cycle lock_valid=1 and the owner does not request.
  - Counter resets on each owner request.
  - At LOCK_MAX the lock is force-released and the counter clears.
- Reset (asynchronous, any time):
  - last_grant=1 (m0 wins the first tie), lock_valid=0, counter=0, rd_vld=0.
  - While reset=1: both waitrequest=1, readdatavalid=0, ram_chipselect=0, ram_write=0.
  - An in-flight read is dropped.

## Timing
- Write: accepted in the cycle waitrequest=0; the RAM writes at that edge.
- Read: address accepted at cycle T; readdatavalid=1 at T+1 with data. Fixed latency 1, no stalls.
- Throughput is one access per cycle total. Under sustained dual requests with no lock, grants strictly alternate m0, m1, m0, …
- Read-after-write to the same address by either master in consecutive cycles returns the new data, because the write precedes the read by at least one edge.
- Simultaneous force-release and owner request in the same cycle: the request wins and the counter resets; no release.
- Lock set in cycle T excludes the other master starting at T+1.

## Structure
- Package platform_ram_arb_pkg:
  - master_id_t (1 bit)
  - M0/M1 constants
  - default ADDR_W/DATA_W/BE_W
  - lock counter width function clog2(LOCK_MAX+1)
- Sub-module platform_ram_rr_pick: combinational 2-way round-robin pick.
  - Inputs: req[1:0], last_grant, lock_valid, lock_owner.
  - Outputs: gnt_valid, gnt_id.
- Top holds the registers and muxes.

## Test plan
- After reset, m0 and m1 both read (addr 0x010, 0x020) for 4 cycles. Required:
  - Grants m0, m1, m0, m1.
  - Each readdatavalid one cycle after its grant, with the correct words.
- m0 writes 0xDEADBEEF to 0x100 with byteenable 0b0011, then reads 0x100. Required: low half = 0xBEEF, upper half unchanged.
- m1 read+lock 0x005, then m1 write 0x005 with lock=0, while m0 requests continuously. Required:
  - m0 waitrequest=1 until m1's unlocking write is granted.
  - m0 granted the next cycle.
- m0 locks, then idles while m1 requests. Required:
  - Lock force-released after LOCK_MAX=64 idle cycles.
  - m1 granted the following cycle.
- Reset asserted the cycle after a granted read. Required:
  - No readdatavalid.
  - All waitrequest=1 and ram_chipselect=0 during reset.
  - After release, m0 wins the first tie.
- m0 request alone for 10 cycles. Required: waitrequest=0 every cycle, 10 accesses.
